// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rf_pkg
// Purpose : Shared constants and helpers for the multi-port register file.
//           Default widths, the hardwired-zero address, and the slice helper
//           used to locate one port inside a packed multi-port bus.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned ZERO_ADDR = 0;

  // LSB position of port 'port' in a packed bus of 'width'-bit fields.
  function automatic int unsigned port_lsb(input int unsigned port,
                                           input int unsigned width);
    return port * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_mp_if
// Purpose : Read/write/busy bus of the multi-port register file.
// Ports   : Read_Ctrl, Read_Address (packed per port), Read_Data (packed per
//           port), Read_Busy (per port), Write_Ctrl/Address/Data,
//           Busy_Set/Busy_Address.
//           master = decode/writeback side, slave = register file.
// Revision: 1.0 - initial release
// ============================================================================
interface reg_file_mp_if
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NUM_RD = 2
);

  logic                       Read_Ctrl;
  logic [NUM_RD*ADDR_W-1:0]   Read_Address;
  logic [NUM_RD*DATA_W-1:0]   Read_Data;
  logic [NUM_RD-1:0]          Read_Busy;
  logic                       Write_Ctrl;
  logic [ADDR_W-1:0]          Write_Address;
  logic [DATA_W-1:0]          Write_Data;
  logic                       Busy_Set;
  logic [ADDR_W-1:0]          Busy_Address;

  modport master (
    output Read_Ctrl, Read_Address, Write_Ctrl, Write_Address, Write_Data,
           Busy_Set, Busy_Address,
    input  Read_Data, Read_Busy
  );

  modport slave (
    input  Read_Ctrl, Read_Address, Write_Ctrl, Write_Address, Write_Data,
           Busy_Set, Busy_Address,
    output Read_Data, Read_Busy
  );

endinterface
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module  : rf_read_port
// Purpose : One registered read port: selects the addressed register and its
//           busy bit, applies optional write bypass and hardwired zero, and
//           captures the result when rd_en_i is high.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           rd_en_i, addr_i   - read enable and address
//           regs_i, busy_i    - storage array and busy vector
//           wr_*_i, set_*_i   - same-cycle write and busy-set (bypass)
//           data_o, busy_o    - registered read data and busy flag
// Revision: 1.0 - initial release
// ============================================================================
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              busy_d, busy_q;

  always_comb begin
    data_d = regs_i[addr_i];
    busy_d = busy_i[addr_i];
    // A forwarded write retires the old producer, so the register reads as
    // ready unless a new producer is being issued on the same edge.
    if (BYPASS && wr_en_i && (wr_addr_i == addr_i)) begin
      data_d = wr_data_i;
      busy_d = set_en_i && (set_addr_i == addr_i);
    end
    // Zero register overrides everything, including the bypass path.
    if (ZERO_REG && (addr_i == ADDR_W'(ZERO_ADDR))) begin
      data_d = '0;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else if (rd_en_i) begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_mp
// Purpose : Parametrised multi-read-port register file with hardwired zero,
//           write-to-read bypass and per-register busy scoreboard. Holds the
//           storage, busy vector and write logic; each read port is an
//           rf_read_port instance.
// Ports   : clk  - clock, all state on rising edge
//           rst  - synchronous active-high reset
//           bus  - reg_file_mp_if.slave (read/write/busy bus)
// Revision: 1.0 - initial release
// ============================================================================
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_mp_if.slave bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wr_ok, set_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  // Writes and busy-sets to the hardwired zero register are dropped.
  assign wr_ok  = bus.Write_Ctrl &&
                  !(ZERO_REG && (bus.Write_Address == ADDR_W'(ZERO_ADDR)));
  assign set_ok = bus.Busy_Set &&
                  !(ZERO_REG && (bus.Busy_Address == ADDR_W'(ZERO_ADDR)));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[bus.Write_Address] = bus.Write_Data;
      busy_d[bus.Write_Address] = 1'b0;
    end
    // Applied after the write so a new producer issued on the same edge
    // keeps the register marked pending.
    if (set_ok) begin
      busy_d[bus.Busy_Address] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .rd_en_i    (bus.Read_Ctrl),
      .addr_i     (bus.Read_Address[port_lsb(p, ADDR_W) +: ADDR_W]),
      .regs_i     (regs_q),
      .busy_i     (busy_q),
      .wr_en_i    (bus.Write_Ctrl),
      .wr_addr_i  (bus.Write_Address),
      .wr_data_i  (bus.Write_Data),
      .set_en_i   (bus.Busy_Set),
      .set_addr_i (bus.Busy_Address),
      .data_o     (rd_data[port_lsb(p, DATA_W) +: DATA_W]),
      .busy_o     (rd_busy[p])
    );
  end

  assign bus.Read_Data = rd_data;
  assign bus.Read_Busy = rd_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_file_mp
// Purpose : Self-checking bench for reg_file_mp. Two instances share one
//           stimulus stream: A = 4 ports, bypass on, zero register on;
//           B = 2 ports (ports 0/1 of the stream), bypass off, zero off.
//           A reference model predicts outputs into a scoreboard queue.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;
  import rf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rctl;
  logic [4:0]  ra [4];
  logic        wctl;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        bset;
  logic [4:0]  baddr;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) bus_a ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_b ();

  assign bus_a.Read_Ctrl     = rctl;
  assign bus_a.Read_Address  = {ra[3], ra[2], ra[1], ra[0]};
  assign bus_a.Write_Ctrl    = wctl;
  assign bus_a.Write_Address = waddr;
  assign bus_a.Write_Data    = wdata;
  assign bus_a.Busy_Set      = bset;
  assign bus_a.Busy_Address  = baddr;

  assign bus_b.Read_Ctrl     = rctl;
  assign bus_b.Read_Address  = {ra[1], ra[0]};
  assign bus_b.Write_Ctrl    = wctl;
  assign bus_b.Write_Address = waddr;
  assign bus_b.Write_Data    = wdata;
  assign bus_b.Busy_Set      = bset;
  assign bus_b.Busy_Address  = baddr;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4),
                .BYPASS(1'b1), .ZERO_REG(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2),
                .BYPASS(1'b0), .ZERO_REG(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct packed {
    logic [3:0][31:0] ad;
    logic [3:0]       ab;
    logic [1:0][31:0] bd;
    logic [1:0]       bb;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        held;
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  logic [31:0] bva, bvb;
  int          checks = 0;
  int          errors = 0;

  task automatic idle();
    rst = 1'b0; rctl = 1'b0; wctl = 1'b0; waddr = '0; wdata = '0;
    bset = 1'b0; baddr = '0;
    for (int i = 0; i < 4; i++) ra[i] = '0;
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3);
    ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
  endtask

  // Predict the outputs after the coming edge from the current inputs and
  // model state, then advance the model state.
  task automatic model_push();
    exp_t        nxt;
    logic [4:0]  a;
    nxt = held;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin ma[i] = '0; mb[i] = '0; end
      bva = '0; bvb = '0; nxt = '0;
    end else begin
      if (rctl) begin
        for (int p = 0; p < 4; p++) begin
          a = ra[p];
          if (a == 5'd0) begin
            nxt.ad[p] = '0; nxt.ab[p] = 1'b0;
          end else if (wctl && waddr == a) begin
            nxt.ad[p] = wdata; nxt.ab[p] = bset && (baddr == a);
          end else begin
            nxt.ad[p] = ma[a]; nxt.ab[p] = bva[a];
          end
        end
        for (int p = 0; p < 2; p++) begin
          a = ra[p];
          nxt.bd[p] = mb[a]; nxt.bb[p] = bvb[a];
        end
      end
      if (wctl && waddr != 5'd0) begin ma[waddr] = wdata; bva[waddr] = 1'b0; end
      if (bset && baddr != 5'd0) bva[baddr] = 1'b1;
      if (wctl) begin mb[waddr] = wdata; bvb[waddr] = 1'b0; end
      if (bset) bvb[baddr] = 1'b1;
    end
    held = nxt;
    sb_q.push_back(nxt);
  endtask

  task automatic cycle(input string tag);
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (bus_a.Read_Data[p*32 +: 32] !== e.ad[p]) begin
        errors++;
        $display("FAIL %s A.data[%0d] got %h expected %h", tag, p,
                 bus_a.Read_Data[p*32 +: 32], e.ad[p]);
      end
      checks++;
      if (bus_a.Read_Busy[p] !== e.ab[p]) begin
        errors++;
        $display("FAIL %s A.busy[%0d] got %b expected %b", tag, p,
                 bus_a.Read_Busy[p], e.ab[p]);
      end
    end
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (bus_b.Read_Data[p*32 +: 32] !== e.bd[p]) begin
        errors++;
        $display("FAIL %s B.data[%0d] got %h expected %h", tag, p,
                 bus_b.Read_Data[p*32 +: 32], e.bd[p]);
      end
      checks++;
      if (bus_b.Read_Busy[p] !== e.bb[p]) begin
        errors++;
        $display("FAIL %s B.busy[%0d] got %b expected %b", tag, p,
                 bus_b.Read_Busy[p], e.bb[p]);
      end
    end
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; cycle("reset_init");
    idle(); wctl = 1'b1; waddr = 5'd5; wdata = 32'hABCD; cycle("pre_reset_wr");
    // Reset with reads, a write and a busy-set all asserted: all ignored.
    idle(); rst = 1'b1; rctl = 1'b1; set_ra(5'd18, 5'd20, 5'd5, 5'd5);
    wctl = 1'b1; waddr = 5'd18; wdata = 32'h1; bset = 1'b1; baddr = 5'd20;
    cycle("reset_mid");
    idle(); rctl = 1'b1; set_ra(5'd5, 5'd18, 5'd20, 5'd5); cycle("after_reset");
  endtask

  task automatic test_write_read();
    idle(); wctl = 1'b1; waddr = 5'd20; wdata = 32'd1023; cycle("wr20");
    idle(); rctl = 1'b1; set_ra(5'd18, 5'd20, 5'd18, 5'd20); cycle("rd_18_20");
    idle(); wctl = 1'b1; waddr = 5'd18; wdata = 32'd1553; cycle("wr18");
    idle(); rctl = 1'b1; set_ra(5'd18, 5'd18, 5'd20, 5'd18); cycle("rd18");
  endtask

  task automatic test_bypass();
    idle(); wctl = 1'b1; waddr = 5'd7; wdata = 32'h55;
    rctl = 1'b1; set_ra(5'd7, 5'd7, 5'd7, 5'd7); cycle("bypass_same");
    idle(); rctl = 1'b1; set_ra(5'd7, 5'd7, 5'd7, 5'd7); cycle("bypass_next");
  endtask

  task automatic test_zero();
    idle(); wctl = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    bset = 1'b1; baddr = 5'd0; cycle("zero_wr");
    idle(); rctl = 1'b1; set_ra(5'd0, 5'd0, 5'd0, 5'd0); cycle("zero_rd");
    idle(); wctl = 1'b1; waddr = 5'd0; wdata = 32'h1234;
    rctl = 1'b1; set_ra(5'd0, 5'd0, 5'd0, 5'd0); cycle("zero_bypass");
  endtask

  task automatic test_scoreboard();
    idle(); bset = 1'b1; baddr = 5'd9; cycle("set9");
    idle(); rctl = 1'b1; set_ra(5'd9, 5'd9, 5'd9, 5'd9); cycle("busy9");
    idle(); wctl = 1'b1; waddr = 5'd9; wdata = 32'd42; cycle("wr9");
    idle(); rctl = 1'b1; set_ra(5'd9, 5'd9, 5'd9, 5'd9); cycle("clear9");
    idle(); wctl = 1'b1; waddr = 5'd9; wdata = 32'd43; bset = 1'b1; baddr = 5'd9;
    cycle("wr_set9");
    idle(); rctl = 1'b1; set_ra(5'd9, 5'd9, 5'd9, 5'd9); cycle("set_wins9");
    idle(); wctl = 1'b1; waddr = 5'd9; wdata = 32'd44;
    rctl = 1'b1; set_ra(5'd9, 5'd9, 5'd9, 5'd9); cycle("bypass_busy_clr");
    idle(); wctl = 1'b1; waddr = 5'd9; wdata = 32'd45; bset = 1'b1; baddr = 5'd9;
    rctl = 1'b1; set_ra(5'd9, 5'd9, 5'd9, 5'd9); cycle("bypass_busy_set");
  endtask

  task automatic test_hold();
    idle(); wctl = 1'b1; waddr = 5'd3; wdata = 32'd77; cycle("wr3");
    idle(); rctl = 1'b1; set_ra(5'd3, 5'd3, 5'd3, 5'd3); cycle("multi_77");
    idle(); set_ra(5'd1, 5'd2, 5'd4, 5'd5);
    wctl = 1'b1; waddr = 5'd3; wdata = 32'd99; cycle("hold_77");
    idle(); rctl = 1'b1; set_ra(5'd3, 5'd3, 5'd3, 5'd3); cycle("after_hold");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 80; n++) begin
      idle();
      rst   = ($urandom_range(0, 24) == 0);
      rctl  = $urandom_range(0, 3) != 0;
      wctl  = $urandom_range(0, 1) != 0;
      bset  = $urandom_range(0, 2) == 0;
      waddr = 5'($urandom_range(0, 7));
      baddr = 5'($urandom_range(0, 7));
      wdata = $urandom;
      set_ra(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cycle("b2b");
    end
  endtask

  initial begin
    held = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the pipelined MIPS datapath, successor to the fixed 32×32, two-read/one-write register file. Adds configurable width, depth and read-port count, synchronous clear, hardwired-zero register, write-to-read bypass and a per-register busy scoreboard for hazard detection in the decode stage. Sits in ID; written from WB.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, read ports (1..4)
- BYPASS, 1, 1 = same-cycle write forwarded to matching read; 0 = read returns old value
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- Read_Ctrl  in  1  enable for all read ports
- Read_Address  in  NUM_RD*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
- Read_Data  out  NUM_RD*DATA_W  packed registered read data, port p at [p*DATA_W +: DATA_W]
- Read_Busy  out  NUM_RD  registered busy flag of addressed register, per port
- Write_Ctrl  in  1  write enable
- Write_Address  in  ADDR_W  write address
- Write_Data  in  DATA_W  write data
- Busy_Set  in  1  mark Busy_Address pending (instruction issued with that destination)
- Busy_Address  in  ADDR_W  destination being marked

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits, plus busy bit vector of same depth.
- Write: Write_Ctrl=1 at edge → reg[Write_Address] <= Write_Data and busy[Write_Address] <= 0. ZERO_REG=1 and address 0: write dropped, busy[0] stays 0.
- Busy: Busy_Set=1 at edge → busy[Busy_Address] <= 1. Same edge, same address as a write: set wins (new producer outstanding). Busy_Set on address 0 with ZERO_REG=1 ignored.
- Read: Read_Ctrl=1 at edge → for each port p, Read_Data[p] <= value, Read_Busy[p] <= busy flag. Read_Ctrl=0: both hold.
- Read value: address 0 with ZERO_REG=1 → 0; else if BYPASS=1, Write_Ctrl=1, Write_Address matches → Write_Data; else stored value.
- Read busy with BYPASS=1 and matching write same cycle: reported 0 unless Busy_Set to same address same cycle (then 1).
- Multiple ports on same address return identical data/busy.
- No state machine beyond reset/run; all ports independent, no arbitration.

## Timing
- rst=1 at edge: all registers 0, busy vector 0, Read_Data 0, Read_Busy 0; writes, sets and reads that cycle ignored. Reset mid-stream discards pending writes entirely.
- Read latency 1 cycle: address presented cycle N → data valid after edge N+1 (visible in cycle N+1).
- Write visible to non-bypass read issued the cycle after the write edge; with BYPASS=1 also same cycle.
- Busy set at edge N visible to a read issued cycle N+1.
- Throughput: NUM_RD reads + 1 write + 1 busy set per cycle, no stalls.
- Out-of-range addresses impossible (depth = 2**ADDR_W).

## Structure
- Shared package rf_pkg: default DATA_W/ADDR_W constants, ZERO_ADDR constant, packed-port slice helper functions.
- One sub-module natural: rf_read_port (mux + bypass + zero-check + output register), instantiated NUM_RD times by generate loop; storage, busy vector and write logic in top.

## Test plan
- Reset: rst=1 one cycle, Read_Ctrl=1, addresses 18 and 20 → Read_Data both 0, Read_Busy 0 next cycle; prior contents of reg 5 (0xABCD) read as 0 after reset.
- Write/read: write 1023 to 20; next cycle read 18, 20 → 0 and 1023; write 1553 to 18, read 18 cycle after → 1553.
- Bypass: BYPASS=1, same cycle write 0x55 to 7 and read 7 → 0x55 after edge; BYPASS=0 same stimulus → old value 0, then 0x55 next read.
- Zero register: write 0xFFFF_FFFF to 0, Busy_Set on 0 → read 0 gives 0, busy 0; ZERO_REG=0 build returns 0xFFFF_FFFF.
- Scoreboard: Busy_Set addr 9 → read 9 busy=1; write 9 value 42 → next read 42, busy=0; simultaneous write 9 and Busy_Set 9 → busy=1.
- Read hold / multiport: NUM_RD=4, all ports addr 3 = 77 → all 77; drop Read_Ctrl, change addresses and write 3 → outputs hold 77.
